decode_ctrl: RTL and testbench

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/decode_ctrl_pkg.sv | 106 ++++++++++
 rtl/CTRLWord.sv | 10 +
 rtl/decode_ctrl_decode_unit.sv | 92 +++++++++
 rtl/decode_ctrl.sv | 161 ++++++++++++++++
 tb/tb_decode_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_ctrl_pkg.sv
// decode_ctrl_pkg: shared RV32I word type, issue-queue / execution-unit / immediate /
// uop enums, the decoded-uop record and the immediate packing helpers.
package decode_ctrl_pkg;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IQ_ALU = 2'd0,
    IQ_MEM = 2'd1,
    IQ_BR  = 2'd2
  } iqt;

  localparam int IQT_COUNT = 3;

  typedef enum logic [1:0] {
    EXU_ALU = 2'd0,
    EXU_LSU = 2'd1,
    EXU_BRU = 2'd2
  } exut;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } immt;

  typedef enum logic [4:0] {
    UOP_NOP    = 5'd0,
    UOP_ADD    = 5'd1,
    UOP_SUB    = 5'd2,
    UOP_SLL    = 5'd3,
    UOP_SLT    = 5'd4,
    UOP_SLTU   = 5'd5,
    UOP_XOR    = 5'd6,
    UOP_SRL    = 5'd7,
    UOP_SRA    = 5'd8,
    UOP_OR     = 5'd9,
    UOP_AND    = 5'd10,
    UOP_LUI    = 5'd11,
    UOP_AUIPC  = 5'd12,
    UOP_LOAD   = 5'd13,
    UOP_STORE  = 5'd14,
    UOP_BRANCH = 5'd15,
    UOP_JAL    = 5'd16,
    UOP_JALR   = 5'd17
  } uopc;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    uopc         uopcode;
    iqt          iq_type;
    exut         exu_type;
    immt         imm_type;
    logic [19:0] packed_imm;
    logic        has_rd;
    logic        has_rs1;
    logic        has_rs2;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic        shadowable;
  } uop_t;

  // B and J immediates drop their always-zero LSB so every format fits in 20 bits.
  function automatic logic [19:0] pack_imm(input rv32i_word instr, input immt kind);
    logic [19:0] p;
    case (kind)
      IMM_I:   p = {{8{instr[31]}}, instr[31:20]};
      IMM_S:   p = {{8{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   p = {{8{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8]};
      IMM_U:   p = instr[31:12];
      IMM_J:   p = {instr[31], instr[19:12], instr[20], instr[30:21]};
      default: p = 20'd0;
    endcase
    return p;
  endfunction

  function automatic uopc alu_uop(input logic [2:0] funct3, input logic alt, input logic is_imm);
    uopc u;
    case (funct3)
      3'b000:  u = (alt && !is_imm) ? UOP_SUB : UOP_ADD;
      3'b001:  u = UOP_SLL;
      3'b010:  u = UOP_SLT;
      3'b011:  u = UOP_SLTU;
      3'b100:  u = UOP_XOR;
      3'b101:  u = alt ? UOP_SRA : UOP_SRL;
      3'b110:  u = UOP_OR;
      3'b111:  u = UOP_AND;
      default: u = UOP_NOP;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/CTRLWord.sv
// CTRLWord: carries the raw instruction word into the decoder and the decoded uop back.
interface CTRLWord;
  import decode_ctrl_pkg::*;

  rv32i_word instr;
  uop_t      uop;

  modport dec  (input instr, output uop);
  modport ctrl (output instr, input uop);
endinterface

// File: rtl/decode_ctrl_decode_unit.sv
// decode_unit: purely combinational RV32I decoder producing dispatch uop fields.
module decode_unit
  import decode_ctrl_pkg::*;
(
  CTRLWord.dec cw
);

  uop_t       uop_s;
  logic [6:0] opcode_s;
  logic [2:0] funct3_s;

  assign opcode_s = cw.instr[6:0];
  assign funct3_s = cw.instr[14:12];

  // Format-driven field decode; unknown opcodes fall back to an ALU NOP.
  always_comb begin
    uop_s          = '0;
    uop_s.uopcode  = UOP_NOP;
    uop_s.iq_type  = IQ_ALU;
    uop_s.exu_type = EXU_ALU;
    uop_s.imm_type = IMM_NONE;
    case (opcode_s)
      OPC_OP_IMM: begin
        uop_s.uopcode    = alu_uop(funct3_s, cw.instr[30], 1'b1);
        uop_s.imm_type   = IMM_I;
        uop_s.has_rd     = 1'b1;
        uop_s.has_rs1    = 1'b1;
        uop_s.shadowable = 1'b1;
      end
      OPC_OP: begin
        uop_s.uopcode    = alu_uop(funct3_s, cw.instr[30], 1'b0);
        uop_s.has_rd     = 1'b1;
        uop_s.has_rs1    = 1'b1;
        uop_s.has_rs2    = 1'b1;
        uop_s.shadowable = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        uop_s.uopcode    = (opcode_s == OPC_LUI) ? UOP_LUI : UOP_AUIPC;
        uop_s.imm_type   = IMM_U;
        uop_s.has_rd     = 1'b1;
        uop_s.shadowable = 1'b1;
      end
      OPC_LOAD: begin
        uop_s.uopcode  = UOP_LOAD;
        uop_s.iq_type  = IQ_MEM;
        uop_s.exu_type = EXU_LSU;
        uop_s.imm_type = IMM_I;
        uop_s.has_rd   = 1'b1;
        uop_s.has_rs1  = 1'b1;
      end
      OPC_STORE: begin
        uop_s.uopcode  = UOP_STORE;
        uop_s.iq_type  = IQ_MEM;
        uop_s.exu_type = EXU_LSU;
        uop_s.imm_type = IMM_S;
        uop_s.has_rs1  = 1'b1;
        uop_s.has_rs2  = 1'b1;
      end
      OPC_BRANCH: begin
        uop_s.uopcode  = UOP_BRANCH;
        uop_s.iq_type  = IQ_BR;
        uop_s.exu_type = EXU_BRU;
        uop_s.imm_type = IMM_B;
        uop_s.has_rs1  = 1'b1;
        uop_s.has_rs2  = 1'b1;
        uop_s.is_br    = 1'b1;
      end
      OPC_JAL: begin
        uop_s.uopcode  = UOP_JAL;
        uop_s.iq_type  = IQ_BR;
        uop_s.exu_type = EXU_BRU;
        uop_s.imm_type = IMM_J;
        uop_s.has_rd   = 1'b1;
        uop_s.is_jal   = 1'b1;
      end
      OPC_JALR: begin
        uop_s.uopcode  = UOP_JALR;
        uop_s.iq_type  = IQ_BR;
        uop_s.exu_type = EXU_BRU;
        uop_s.imm_type = IMM_I;
        uop_s.has_rd   = 1'b1;
        uop_s.has_rs1  = 1'b1;
        uop_s.is_jalr  = 1'b1;
      end
      default: uop_s.uopcode = UOP_NOP;
    endcase
    uop_s.packed_imm = pack_imm(cw.instr, uop_s.imm_type);
  end

  assign cw.uop = uop_s;

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: fetch FIFO feeding a one-entry dispatch staging register via decode_unit.
// Defining DECODE_CTRL_PERF_EN adds the stall_cycles / starve_cycles counters.
module decode_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NUM_IQ = IQT_COUNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  rv32i_word         fetch_instr,
  input  logic [31:0]       fetch_pc,
  input  logic [NUM_IQ-1:0] iq_ready,
  output logic              dis_valid,
  output logic [31:0]       dis_pc,
  output uopc               dis_uopcode,
  output iqt                dis_iq_type,
  output exut               dis_exu_type,
  output immt               dis_imm_type,
  output logic [19:0]       dis_packed_imm,
  output logic              dis_has_rd,
  output logic              dis_has_rs1,
  output logic              dis_has_rs2,
  output logic              dis_is_br,
  output logic              dis_is_jal,
  output logic              dis_is_jalr,
  output logic              dis_shadowable
`ifdef DECODE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       starve_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    rv32i_word   instr;
  } fifo_entry_t;

  fifo_entry_t mem_r [DEPTH];
  logic [AW:0] wptr_r, rptr_r;
  logic        empty_s, full_s, enq_s, load_s, fire_s, sel_ready_s;
  state_t      state_r, state_nx_s;
  logic [31:0] pc_r;
  uop_t        uop_r;

  CTRLWord cw ();

  decode_unit u_decode (.cw(cw));

  assign empty_s     = (wptr_r == rptr_r);
  assign full_s      = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
  assign fetch_ready = !full_s;
  assign enq_s       = fetch_valid && !full_s && !flush;
  assign dis_valid   = (state_r == ST_FULL);
  assign fire_s      = dis_valid && sel_ready_s;
  assign load_s      = !empty_s && (!dis_valid || fire_s) && !flush;
  assign cw.instr    = mem_r[rptr_r[AW-1:0]].instr;

  // Select the ready bit of the queue the staged uop targets.
  always_comb begin
    sel_ready_s = 1'b0;
    for (int i = 0; i < NUM_IQ; i++) begin
      sel_ready_s = sel_ready_s | (iq_ready[i] & (int'(uop_r.iq_type) == i));
    end
  end

  // Staging FSM next state.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_EMPTY: state_nx_s = load_s ? ST_FULL : ST_EMPTY;
      ST_FULL:  state_nx_s = (fire_s && !load_s) ? ST_EMPTY : ST_FULL;
      default:  state_nx_s = ST_EMPTY;
    endcase
  end

  // Staging FSM state register; flush wins over any same-edge load or fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else if (flush) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FIFO payload storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      mem_r[wptr_r[AW-1:0]] <= '{pc: fetch_pc, instr: fetch_instr};
    end
  end

  // FIFO pointers and the staged uop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r <= '0;
      rptr_r <= '0;
      pc_r   <= 32'd0;
      uop_r  <= '0;
    end else if (flush) begin
      wptr_r <= '0;
      rptr_r <= '0;
      pc_r   <= 32'd0;
      uop_r  <= '0;
    end else begin
      if (enq_s) begin
        wptr_r <= wptr_r + (AW+1)'(1);
      end
      if (load_s) begin
        rptr_r <= rptr_r + (AW+1)'(1);
        pc_r   <= mem_r[rptr_r[AW-1:0]].pc;
        uop_r  <= cw.uop;
      end
    end
  end

  assign dis_pc         = pc_r;
  assign dis_uopcode    = uop_r.uopcode;
  assign dis_iq_type    = uop_r.iq_type;
  assign dis_exu_type   = uop_r.exu_type;
  assign dis_imm_type   = uop_r.imm_type;
  assign dis_packed_imm = uop_r.packed_imm;
  assign dis_has_rd     = uop_r.has_rd;
  assign dis_has_rs1    = uop_r.has_rs1;
  assign dis_has_rs2    = uop_r.has_rs2;
  assign dis_is_br      = uop_r.is_br;
  assign dis_is_jal     = uop_r.is_jal;
  assign dis_is_jalr    = uop_r.is_jalr;
  assign dis_shadowable = uop_r.shadowable;

`ifdef DECODE_CTRL_PERF_EN
  // Saturating stall/starve counters; flush does not affect them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles  <= 32'd0;
      starve_cycles <= 32'd0;
    end else begin
      if (dis_valid && !fire_s && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (!dis_valid && empty_s && (starve_cycles != 32'hFFFF_FFFF)) begin
        starve_cycles <= starve_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: table-driven decode vectors plus directed sequences, checked by a
// scoreboard queue filled on accepted fetches and drained on dispatch fires.
module tb_decode_ctrl;
  import decode_ctrl_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    uopc         uop;
    iqt          iq;
    exut         exu;
    immt         immk;
    logic [19:0] pimm;
    logic [6:0]  flags;  // {has_rd, has_rs1, has_rs2, is_br, is_jal, is_jalr, shadowable}
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, fetch_valid, fetch_ready;
  rv32i_word   fetch_instr;
  logic [31:0] fetch_pc;
  logic [IQT_COUNT-1:0] iq_ready;
  logic        dis_valid;
  logic [31:0] dis_pc;
  uopc         dis_uopcode;
  iqt          dis_iq_type;
  exut         dis_exu_type;
  immt         dis_imm_type;
  logic [19:0] dis_packed_imm;
  logic        dis_has_rd, dis_has_rs1, dis_has_rs2, dis_is_br, dis_is_jal, dis_is_jalr, dis_shadowable;
`ifdef DECODE_CTRL_PERF_EN
  logic [31:0] stall_cycles, starve_cycles;
  logic [31:0] stall_base;
`endif

  decode_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .iq_ready(iq_ready),
    .dis_valid(dis_valid), .dis_pc(dis_pc), .dis_uopcode(dis_uopcode),
    .dis_iq_type(dis_iq_type), .dis_exu_type(dis_exu_type), .dis_imm_type(dis_imm_type),
    .dis_packed_imm(dis_packed_imm), .dis_has_rd(dis_has_rd), .dis_has_rs1(dis_has_rs1),
    .dis_has_rs2(dis_has_rs2), .dis_is_br(dis_is_br), .dis_is_jal(dis_is_jal),
    .dis_is_jalr(dis_is_jalr), .dis_shadowable(dis_shadowable)
`ifdef DECODE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .starve_cycles(starve_cycles)
`endif
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  vec_t sbq[$];
  int   fire_log[$];
  vec_t cur;
  vec_t tbl[11];

  function automatic logic [70:0] exp_bits(input vec_t v);
    return {v.pc, v.uop, v.iq, v.exu, v.immk, v.pimm, v.flags};
  endfunction

  function automatic logic [70:0] obs_bits();
    return {dis_pc, dis_uopcode, dis_iq_type, dis_exu_type, dis_imm_type, dis_packed_imm,
            dis_has_rd, dis_has_rs1, dis_has_rs2, dis_is_br, dis_is_jal, dis_is_jalr, dis_shadowable};
  endfunction

  function automatic vec_t mk_addi(input logic [4:0] rd, input logic [11:0] imm, input logic [31:0] pc);
    vec_t v;
    v.instr = {imm, 5'd0, 3'b000, rd, 7'b0010011};
    v.pc    = pc;
    v.uop   = UOP_ADD;
    v.iq    = IQ_ALU;
    v.exu   = EXU_ALU;
    v.immk  = IMM_I;
    v.pimm  = {{8{imm[11]}}, imm};
    v.flags = 7'b1100001;
    return v;
  endfunction

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    fetch_valid = 1'b1;
    fetch_instr = v.instr;
    fetch_pc    = v.pc;
    cur         = v;
  endtask

  // One clock: predict fire/enqueue from pre-edge values, then advance to the next negedge.
  task automatic step();
    logic [3:0] rdy4;
    vec_t       v;
    rdy4 = {1'b0, iq_ready};
    if (!rst) begin
      if (flush) begin
        sbq.delete();
      end else begin
        if (dis_valid === 1'b1 && rdy4[dis_iq_type] === 1'b1) begin
          fire_log.push_back(cyc);
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fire: got pc %h expected no dispatch", dis_pc);
          end else begin
            v = sbq.pop_front();
            chk("dispatch", obs_bits(), exp_bits(v));
          end
        end
        if (fetch_valid && fetch_ready === 1'b1) sbq.push_back(cur);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    fetch_valid = 1'b0;
    while ((sbq.size() != 0 || dis_valid === 1'b1) && n < bound) begin
      step();
      n++;
    end
    chk("drain_done", 71'(sbq.size()), 71'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0]  = '{32'h00500093, 32'h1000, UOP_ADD,    IQ_ALU, EXU_ALU, IMM_I,    20'h00005, 7'b1100001};
    tbl[1]  = '{32'h002081B3, 32'h1004, UOP_ADD,    IQ_ALU, EXU_ALU, IMM_NONE, 20'h00000, 7'b1110001};
    tbl[2]  = '{32'h402081B3, 32'h1008, UOP_SUB,    IQ_ALU, EXU_ALU, IMM_NONE, 20'h00000, 7'b1110001};
    tbl[3]  = '{32'h00812283, 32'h100C, UOP_LOAD,   IQ_MEM, EXU_LSU, IMM_I,    20'h00008, 7'b1100000};
    tbl[4]  = '{32'h00512623, 32'h1010, UOP_STORE,  IQ_MEM, EXU_LSU, IMM_S,    20'h0000C, 7'b0110000};
    tbl[5]  = '{32'hFE208EE3, 32'h1014, UOP_BRANCH, IQ_BR,  EXU_BRU, IMM_B,    20'hFFFFE, 7'b0111000};
    tbl[6]  = '{32'h010000EF, 32'h1018, UOP_JAL,    IQ_BR,  EXU_BRU, IMM_J,    20'h00008, 7'b1000100};
    tbl[7]  = '{32'h00008067, 32'h101C, UOP_JALR,   IQ_BR,  EXU_BRU, IMM_I,    20'h00000, 7'b1100010};
    tbl[8]  = '{32'h123453B7, 32'h1020, UOP_LUI,    IQ_ALU, EXU_ALU, IMM_U,    20'h12345, 7'b1000001};
    tbl[9]  = '{32'hFFF0C213, 32'h1024, UOP_XOR,    IQ_ALU, EXU_ALU, IMM_I,    20'hFFFFF, 7'b1100001};
    tbl[10] = '{32'h4041D113, 32'h1028, UOP_SRA,    IQ_ALU, EXU_ALU, IMM_I,    20'h00404, 7'b1100001};

    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_instr = 32'd0; fetch_pc = 32'd0;
    iq_ready = 3'b111;
    repeat (3) @(negedge clk);
    chk("rst_held_valid", 71'(dis_valid), 71'd0);
    rst = 1'b0;
    #1;
    chk("rst_valid", 71'(dis_valid), 71'd0);
    chk("rst_ready", 71'(fetch_ready), 71'd1);
    chk("rst_fields", obs_bits(), 71'd0);
`ifdef DECODE_CTRL_PERF_EN
    chk("rst_stall_cnt", 71'(stall_cycles), 71'd0);
`endif
    @(negedge clk);

    // Minimum latency: enqueue at edge 0, visible after edge 1, fires at the next edge.
    drive(tbl[0]);
    step();
    fetch_valid = 1'b0;
    chk("lat_after_edge0", 71'(dis_valid), 71'd0);
    step();
    chk("lat_after_edge1", 71'(dis_valid), 71'd1);
    chk("lat_has_rd", 71'(dis_has_rd), 71'd1);
    chk("lat_imm", 71'(dis_packed_imm), 71'd5);
    step();
    chk("lat_fired", 71'(dis_valid), 71'd0);

    // Decode table, one instruction per cycle.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i]);
      step();
    end
    drain(40);

    // Backpressure: fill staging + FIFO, then offer a sixth while full.
    iq_ready = 3'b000;
    for (int k = 0; k < 4; k++) begin
      drive(mk_addi(5'(k + 1), 12'(k), 32'h200 + 32'(4 * k)));
      step();
    end
    chk("bp_ready_after4", 71'(fetch_ready), 71'd1);
    chk("bp_valid", 71'(dis_valid), 71'd1);
    chk("bp_pc", 71'(dis_pc), 71'h200);
    drive(mk_addi(5'd5, 12'd4, 32'h210));
    step();
    drive(mk_addi(5'd6, 12'd5, 32'h214));
    for (int k = 0; k < 3; k++) begin
      chk("bp_full", 71'(fetch_ready), 71'd0);
      chk("bp_stable", obs_bits(), exp_bits(mk_addi(5'd1, 12'd0, 32'h200)));
      step();
    end
    iq_ready = 3'b111;
    step();
    chk("bp_ready_after_pop", 71'(fetch_ready), 71'd1);
    drain(40);

    // Back-to-back stream of eight ALU ops.
    fire_log.delete();
    for (int k = 0; k < 8; k++) begin
      drive(mk_addi(5'(k + 1), 12'(k + 16), 32'h300 + 32'(4 * k)));
      step();
    end
    drain(40);
    chk("stream_fires", 71'(fire_log.size()), 71'd8);
    if (fire_log.size() == 8) chk("stream_consecutive", 71'(fire_log[7] - fire_log[0]), 71'd7);

    // Branch held while only its own queue is blocked.
    iq_ready = 3'b011;
    v = tbl[5];
    v.pc = 32'h400;
    drive(v);
    step();
    fetch_valid = 1'b0;
    step();
`ifdef DECODE_CTRL_PERF_EN
    stall_base = stall_cycles;
`endif
    for (int k = 0; k < 5; k++) begin
      chk("br_blocked", 71'(dis_valid), 71'd1);
      step();
    end
`ifdef DECODE_CTRL_PERF_EN
    chk("br_stall_cnt", 71'(stall_cycles - stall_base), 71'd5);
`endif
    iq_ready = 3'b100;
    step();
    chk("br_fired", 71'(dis_valid), 71'd0);
    iq_ready = 3'b111;
    drain(20);

    // Flush coincident with enqueue and fire.
    iq_ready = 3'b000;
    drive(mk_addi(5'd1, 12'd1, 32'h500));
    step();
    drive(mk_addi(5'd2, 12'd2, 32'h504));
    step();
    iq_ready = 3'b111;
    drive(mk_addi(5'd3, 12'd3, 32'h508));
    flush = 1'b1;
    step();
    flush = 1'b0;
    fetch_valid = 1'b0;
    chk("flush_valid", 71'(dis_valid), 71'd0);
    chk("flush_ready", 71'(fetch_ready), 71'd1);
    step();
    chk("flush_fifo_empty", 71'(dis_valid), 71'd0);
    drive(mk_addi(5'd4, 12'd4, 32'h50C));
    step();
    drain(20);

    // Asynchronous reset mid-stream.
    iq_ready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      drive(mk_addi(5'(k + 1), 12'(k), 32'h600 + 32'(4 * k)));
      step();
    end
    fetch_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 71'(dis_valid), 71'd0);
    chk("arst_fields", obs_bits(), 71'd0);
    sbq.delete();
    @(posedge clk);
    #2;
    chk("arst_hold_valid", 71'(dis_valid), 71'd0);
    @(negedge clk);
    rst = 1'b0;
    iq_ready = 3'b111;
    drive(mk_addi(5'd7, 12'd7, 32'h700));
    step();
    fetch_valid = 1'b0;
    chk("arst_lat_edge0", 71'(dis_valid), 71'd0);
    step();
    chk("arst_lat_edge1", 71'(dis_valid), 71'd1);
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
